// File: rtl/camera_capture_sequencer.sv
// Camera frame-grab sequencer: ping-pongs captures between two DDR frame buffers,
// publishes the last complete frame to a consumer, and handles timeout/retry and fault recovery.
module camera_capture_sequencer #(
  parameter logic [19:0] BUF0_BASE         = 20'd0,
  parameter logic [19:0] BUF1_BASE         = 20'd76800,
  parameter int unsigned ENABLE_LOW_CYCLES = 16,
  parameter logic [31:0] GRAB_TIMEOUT      = 32'd4000000,
  parameter int unsigned MAX_RETRIES       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  input  logic        all_dcms_locked,
  input  logic        camera_present,
  input  logic        grab_done,
  output logic        grab_enable,
  output logic [19:0] data_write_offset,
  output logic        frame_valid,
  output logic [19:0] frame_base,
  input  logic        frame_lock,
  output logic [15:0] frame_count,
  output logic        busy,
  output logic        error,
  output logic [1:0]  error_code
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM      = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_GRAB     = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;
  localparam logic [2:0] S_WAIT_BUF = 3'd5;
  localparam logic [2:0] S_FAULT    = 3'd6;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NO_CAM  = 2'b10;
  localparam logic [1:0] ERR_DCM     = 2'b11;

  localparam logic [31:0] LOW_LAST     = 32'(ENABLE_LOW_CYCLES) - 32'd1;
  localparam logic [31:0] TIMEOUT_LAST = GRAB_TIMEOUT - 32'd1;
  localparam logic [31:0] RETRY_LIMIT  = 32'(MAX_RETRIES);

  logic [2:0]  state_q, state_d;
  logic [31:0] low_cnt_q, low_cnt_d;
  logic [31:0] grab_timer_q, grab_timer_d;
  logic [31:0] retry_cnt_q, retry_cnt_d;
  logic        write_sel_q, write_sel_d;
  logic        stop_hold_q, stop_hold_d;
  logic        grab_enable_q, grab_enable_d;
  logic [19:0] data_write_offset_q, data_write_offset_d;
  logic        frame_valid_q, frame_valid_d;
  logic [19:0] frame_base_q, frame_base_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic [1:0]  error_code_q, error_code_d;

  logic [19:0] target_base;
  logic        in_busy_state;
  logic        dcm_loss;

  assign target_base   = write_sel_q ? BUF1_BASE : BUF0_BASE;
  assign in_busy_state = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign dcm_loss      = in_busy_state && !all_dcms_locked;

  always_comb begin
    state_d             = state_q;
    low_cnt_d           = low_cnt_q;
    grab_timer_d        = grab_timer_q;
    retry_cnt_d         = retry_cnt_q;
    write_sel_d         = write_sel_q;
    stop_hold_d         = stop_hold_q;
    grab_enable_d       = grab_enable_q;
    data_write_offset_d = data_write_offset_q;
    frame_valid_d       = frame_valid_q;
    frame_base_d        = frame_base_q;
    frame_count_d       = frame_count_q;
    error_d             = error_q;
    error_code_d        = error_code_q;

    // Losing the clocks invalidates whatever the camera is doing, so it overrides done/stop.
    if (dcm_loss) begin
      state_d       = S_FAULT;
      grab_enable_d = 1'b0;
      stop_hold_d   = 1'b0;
      error_d       = 1'b1;
      error_code_d  = ERR_DCM;
    end else begin
      case (state_q)
        S_IDLE: begin
          grab_enable_d = 1'b0;
          if (start && all_dcms_locked) begin
            state_d      = S_ARM;
            low_cnt_d    = 32'd0;
            retry_cnt_d  = 32'd0;
            error_d      = 1'b0;
            error_code_d = ERR_NONE;
          end
        end

        S_ARM: begin
          grab_enable_d = 1'b0;
          if (stop) begin
            state_d = S_IDLE;
          end else if (low_cnt_q == LOW_LAST) begin
            state_d = S_CHECK;
          end else begin
            low_cnt_d = low_cnt_q + 32'd1;
          end
        end

        S_CHECK: begin
          if (stop) begin
            state_d       = S_IDLE;
            grab_enable_d = 1'b0;
          end else if (frame_valid_q && frame_lock && (frame_base_q == target_base)) begin
            state_d = S_WAIT_BUF;
          end else if (!camera_present) begin
            state_d       = S_FAULT;
            grab_enable_d = 1'b0;
            error_d       = 1'b1;
            error_code_d  = ERR_NO_CAM;
          end else begin
            state_d             = S_GRAB;
            data_write_offset_d = target_base;
            grab_enable_d       = 1'b1;
            grab_timer_d        = 32'd0;
          end
        end

        S_WAIT_BUF: begin
          grab_enable_d = 1'b0;
          if (stop) begin
            state_d = S_IDLE;
          end else if (!frame_lock) begin
            state_d = S_CHECK;
          end
        end

        S_GRAB: begin
          grab_timer_d = grab_timer_q + 32'd1;
          if (grab_done) begin
            // A stop arriving with done still publishes; remember it for the release cycle.
            state_d     = S_RELEASE;
            stop_hold_d = stop;
          end else if (stop) begin
            state_d       = S_IDLE;
            grab_enable_d = 1'b0;
          end else if (grab_timer_q == TIMEOUT_LAST) begin
            grab_enable_d = 1'b0;
            if (retry_cnt_q < RETRY_LIMIT) begin
              state_d     = S_ARM;
              retry_cnt_d = retry_cnt_q + 32'd1;
              low_cnt_d   = 32'd0;
            end else begin
              state_d      = S_FAULT;
              error_d      = 1'b1;
              error_code_d = ERR_TIMEOUT;
            end
          end
        end

        S_RELEASE: begin
          grab_enable_d = 1'b0;
          frame_base_d  = data_write_offset_q;
          frame_valid_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          write_sel_d   = !write_sel_q;
          retry_cnt_d   = 32'd0;
          stop_hold_d   = 1'b0;
          if (continuous && !stop && !stop_hold_q) begin
            state_d   = S_ARM;
            low_cnt_d = 32'd0;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_FAULT: begin
          grab_enable_d = 1'b0;
          if (start && all_dcms_locked) begin
            state_d      = S_ARM;
            low_cnt_d    = 32'd0;
            retry_cnt_d  = 32'd0;
            error_d      = 1'b0;
            error_code_d = ERR_NONE;
          end else if (stop) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d       = S_IDLE;
          grab_enable_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= S_IDLE;
      low_cnt_q           <= 32'd0;
      grab_timer_q        <= 32'd0;
      retry_cnt_q         <= 32'd0;
      write_sel_q         <= 1'b0;
      stop_hold_q         <= 1'b0;
      grab_enable_q       <= 1'b0;
      data_write_offset_q <= BUF0_BASE;
      frame_valid_q       <= 1'b0;
      frame_base_q        <= BUF0_BASE;
      frame_count_q       <= 16'd0;
      busy_q              <= 1'b0;
      error_q             <= 1'b0;
      error_code_q        <= ERR_NONE;
    end else begin
      state_q             <= state_d;
      low_cnt_q           <= low_cnt_d;
      grab_timer_q        <= grab_timer_d;
      retry_cnt_q         <= retry_cnt_d;
      write_sel_q         <= write_sel_d;
      stop_hold_q         <= stop_hold_d;
      grab_enable_q       <= grab_enable_d;
      data_write_offset_q <= data_write_offset_d;
      frame_valid_q       <= frame_valid_d;
      frame_base_q        <= frame_base_d;
      frame_count_q       <= frame_count_d;
      busy_q              <= busy_d;
      error_q             <= error_d;
      error_code_q        <= error_code_d;
    end
  end

  assign grab_enable       = grab_enable_q;
  assign data_write_offset = data_write_offset_q;
  assign frame_valid       = frame_valid_q;
  assign frame_base        = frame_base_q;
  assign frame_count       = frame_count_q;
  assign busy              = busy_q;
  assign error             = error_q;
  assign error_code        = error_code_q;

endmodule
